tns_link_scheduler: RTL and testbench
=====================================

Name: tns_link_scheduler

Overview:
- Shares one 33-TSV TNS encoder between NUM_REQ requesters. Each requester offers 30-bit source words.
- Arbitrates round-robin with bounded bursts, range-checks every word, drives the encoder input and holds it stable when idle.
- Monitors the encoded 33-bit TSV bus for Mosaic-3C1S group-rule violations.
- Sits between on-die producers and the encoder/TSV interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 30, source word width; equals encoder input width.
- MAX_WORD, 847425747, largest legal source word.
- MAX_BURST, 4, maximum consecutive beats granted to one owner.
- NGRP, 11, number of 3-TSV groups; TSV bus width is 3*NGRP.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; a word transfers when valid and ready are both high.
- enc_data  out  DATA_W  registered encoder input.
- enc_valid  out  1  enc_data carries a new accepted word this cycle.
- enc_src  out  $clog2(NUM_REQ)  index of the requester owning enc_data.
- tsv_mon  in  3*NGRP  encoder TSV output, fed back for monitoring.
- err_range  out  1  one-cycle pulse when a word > MAX_WORD is dropped.
- err_src  out  $clog2(NUM_REQ)  requester that caused the last range error.
- rule_viol  out  1  one-cycle pulse on a TSV rule violation.
- viol_count  out  16  saturating count of violating cycles.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, rr_ptr=0, enc_data=0, enc_valid=0, enc_src=0, req_ready=0, err_range=0, err_src=0, rule_viol=0, viol_count=0, prev_top bits=0.
- FSM states:
  - IDLE: when any req_valid is high, pick the first valid requester at or after rr_ptr (cyclic order) and go to ACTIVE with owner=that index and beat=0. Otherwise stay in IDLE.
  - ACTIVE: req_ready[owner]=1 combinationally. All other ready bits are 0.
    - On a transfer, increment beat.
    - Go to SWITCH if beat reaches MAX_BURST, or if req_valid[owner] is low in a cycle.
    - Otherwise stay in ACTIVE.
  - SWITCH: one turnaround cycle. All ready bits are 0 and enc_data is held. Set rr_ptr=(owner+1) mod NUM_REQ. Next state is IDLE.
- Transfer of an in-range word: enc_data<=word, enc_src<=owner, enc_valid<=1 on the next edge. Latency from transfer edge to enc_data is 1 cycle.
- Transfer of an out-of-range word (>MAX_WORD): the word is consumed (ready stays high) but not forwarded. enc_data is held, enc_valid<=0, err_range<=1, err_src<=owner. The word still counts as a burst beat.
- With no transfer, enc_data holds its previous value so the TSVs stay static. enc_valid is 0 on every cycle without a new word.
- Min-to-max grant: a lone requester streaming continuously gets MAX_BURST beats, then 1 SWITCH cycle, then 1 IDLE cycle, then is re-granted. Throughput is MAX_BURST/(MAX_BURST+2).
- Monitor, evaluated every cycle on tsv_mon, for each group j (bits 3j..3j+2):
  - Violation if bits = {b0=0, b1=0, b2=1} and prev_top[j]=0.
  - Violation if bits = {b0=1, b1=1, b2=0} and prev_top[j]=1.
  - rule_viol<=OR of all groups. viol_count increments by 1 per violating cycle and saturates at 0xFFFF.
  - prev_top[j]<=tsv_mon[3j+2] every cycle.
- Reset asserted mid-burst: everything returns to reset values immediately. Any in-flight word is lost, and arbitration restarts at requester 0.
- req_data must be stable while valid is high and ready is low.

Decomposition:
- Package tns_pkg holds:
  - constants DATA_W, NGRP, MAX_WORD;
  - typedef src_word_t (logic [DATA_W-1:0]);
  - typedef tsv_bus_t (logic [3*NGRP-1:0]);
  - state enum {IDLE, ACTIVE, SWITCH}.
- Sub-module tns_rule_monitor, containing the prev_top register, per-group checks and the saturating counter. It is reusable on the receive side.

Test Plan:
- All four requesters valid with streams 100,101,...: grant order is 0,1,2,3,0. Each owner gets 4 beats, then SWITCH and IDLE cycles. enc_data shows 4 consecutive words per enc_src.
- Requester 2 sends 847425747 then 847425748: the first word reaches enc_data with enc_valid=1. The second is consumed with err_range=1, err_src=2, and enc_data stays 847425747.
- Requester 1 drops valid after 2 beats: SWITCH occurs on the next cycle, and rr_ptr=2 afterwards.
- No requests for 10 cycles after word 356: enc_data stays 356 and enc_valid stays 0 throughout.
- Force tsv_mon group 0 to 000 then 001: rule_viol pulses and viol_count=1. Then force 111 then 110: a second violation, viol_count=2. 000 then 110 gives no violation.
- Assert reset_n=0 for one cycle mid-burst of requester 3: all outputs return to 0 asynchronously, and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/tns_pkg.sv
// Shared types and constants for the TNS link scheduler and its TSV rule monitor.
package tns_pkg;

    localparam int unsigned DATA_W = 30;
    localparam int unsigned NGRP   = 11;
    localparam logic [DATA_W-1:0] MAX_WORD = 30'd847425747;

    typedef logic [DATA_W-1:0] src_word_t;
    typedef logic [3*NGRP-1:0] tsv_bus_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SWITCH
    } sched_state_t;

endpackage

// File: rtl/tns_rule_monitor.sv
// Mosaic-3C1S group-rule checker on a 3*NGRP TSV bus with a saturating violation counter.
module tns_rule_monitor #(
    parameter int unsigned NGRP = 11
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3*NGRP-1:0]   tsv,
    output logic                rule_viol,
    output logic [15:0]         viol_count
);
    import tns_pkg::*;

    logic [NGRP-1:0] prev_top;
    logic [NGRP-1:0] cur_top;
    logic [NGRP-1:0] hit;

    // Per-group rule check against the top bit seen on the previous cycle.
    always_comb begin
        hit     = '0;
        cur_top = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            cur_top[j] = tsv[3*j+2];
            hit[j] = ((tsv[3*j +: 3] == 3'b100) && !prev_top[j]) ||
                     ((tsv[3*j +: 3] == 3'b011) &&  prev_top[j]);
        end
    end

    // History register, violation pulse and saturating counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_top   <= '0;
            rule_viol  <= 1'b0;
            viol_count <= '0;
        end else begin
            prev_top  <= cur_top;
            rule_viol <= |hit;
            if ((|hit) && (viol_count != '1))
                viol_count <= viol_count + 16'd1;
        end
    end

endmodule

// File: rtl/tns_link_scheduler.sv
// Round-robin, burst-limited arbiter feeding a shared TNS encoder, with range
// filtering of source words and a TSV rule monitor on the encoder output.
module tns_link_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 30,
    parameter logic [DATA_W-1:0] MAX_WORD = 30'd847425747,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned NGRP      = 11,
    localparam int unsigned SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           enc_data,
    output logic                        enc_valid,
    output logic [SRC_W-1:0]            enc_src,
    input  logic [3*NGRP-1:0]           tsv_mon,
    output logic                        err_range,
    output logic [SRC_W-1:0]            err_src,
    output logic                        rule_viol,
    output logic [15:0]                 viol_count
);
    import tns_pkg::*;

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    sched_state_t      state_q, state_d;
    logic [SRC_W-1:0]  owner_q, owner_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic              found;
    logic [SRC_W-1:0]  pick;
    int unsigned       idx;
    logic              xfer;
    logic [DATA_W-1:0] word;

    // First valid requester at or after the round-robin pointer, cyclically.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!found && req_valid[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SRC_W-1:0];
            end
        end
    end

    // Arbiter next-state, burst accounting and ready generation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beat_d    = beat_q;
        rr_d      = rr_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACTIVE;
                    owner_d = pick;
                    beat_d  = '0;
                end
            end
            ACTIVE: begin
                req_ready[owner_q] = 1'b1;
                if (req_valid[owner_q]) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_d == BEAT_W'(MAX_BURST))
                        state_d = SWITCH;
                end else begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                rr_d    = (owner_q == SRC_W'(NUM_REQ - 1)) ? '0 : owner_q + SRC_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    // Word offered by the current owner and the handshake qualifier.
    always_comb begin
        xfer = (state_q == ACTIVE) && req_valid[owner_q];
        word = req_data[32'(owner_q) * DATA_W +: DATA_W];
    end

    // Encoder input register: holds its value unless an in-range word arrives,
    // so the TSVs stay static while idle; out-of-range words only raise an error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enc_data  <= '0;
            enc_valid <= 1'b0;
            enc_src   <= '0;
            err_range <= 1'b0;
            err_src   <= '0;
        end else begin
            enc_valid <= 1'b0;
            err_range <= 1'b0;
            if (xfer) begin
                if (word > MAX_WORD) begin
                    err_range <= 1'b1;
                    err_src   <= owner_q;
                end else begin
                    enc_data  <= word;
                    enc_src   <= owner_q;
                    enc_valid <= 1'b1;
                end
            end
        end
    end

    tns_rule_monitor #(
        .NGRP(NGRP)
    ) u_mon (
        .clock      (clock),
        .reset_n    (reset_n),
        .tsv        (tsv_mon),
        .rule_viol  (rule_viol),
        .viol_count (viol_count)
    );

endmodule

// File: tb/tb_tns_link_scheduler.sv
// Directed, table-driven bench for tns_link_scheduler.
module tb_tns_link_scheduler;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 30;
    localparam int unsigned NG  = 11;
    localparam logic [29:0] MAXW = 30'd847425747;

    logic              clock;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     enc_data;
    logic              enc_valid;
    logic [1:0]        enc_src;
    logic [3*NG-1:0]   tsv_mon;
    logic              err_range;
    logic [1:0]        err_src;
    logic              rule_viol;
    logic [15:0]       viol_count;

    tns_link_scheduler #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_WORD  (MAXW),
        .MAX_BURST (4),
        .NGRP      (NG)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .enc_data   (enc_data),
        .enc_valid  (enc_valid),
        .enc_src    (enc_src),
        .tsv_mon    (tsv_mon),
        .err_range  (err_range),
        .err_src    (err_src),
        .rule_viol  (rule_viol),
        .viol_count (viol_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic        ev;
        logic [29:0] ed;
        logic [1:0]  es;
    } arb_vec_t;

    typedef struct {
        logic [32:0] tsv;
        logic        viol;
        logic [15:0] cnt;
    } mon_vec_t;

    arb_vec_t    arb_tab[30];
    mon_vec_t    mon_tab[13];
    logic [29:0] words[NR];
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NR; k++)
            req_data[k*DW +: DW] = words[k];
    endtask

    // Advance one clock; each requester steps to its next word after a handshake.
    task automatic tick();
        logic [3:0] hs;
        hs = req_valid & req_ready;
        @(posedge clock);
        #1;
        for (int k = 0; k < NR; k++)
            if (hs[k]) words[k] = words[k] + 30'd1;
        pack();
    endtask

    function automatic logic [32:0] grp(input int j, input logic b0, input logic b1, input logic b2);
        logic [32:0] v;
        v = 33'({b2, b1, b0});
        return v << (3 * j);
    endfunction

    initial begin
        logic [29:0] last_d;
        logic [1:0]  last_s;
        checks = 0;
        errors = 0;

        // Four-way streaming: 6-cycle period per owner (4 beats, SWITCH, IDLE).
        last_d = '0;
        last_s = '0;
        for (int c = 0; c < 30; c++) begin
            arb_tab[c].valid = 4'b1111;
            arb_tab[c].ready = 4'b0000;
            arb_tab[c].ev    = 1'b0;
            if (c >= 1 && (c - 1) % 6 < 4)
                arb_tab[c].ready = 4'(1 << (((c - 1) / 6) % 4));
            if (c >= 2 && (c - 2) % 6 < 4) begin
                last_d = 30'(100 * ((((c - 2) / 6) % 4) + 1) + (((c - 2) / 6) / 4) * 4 + (c - 2) % 6);
                last_s = 2'(((c - 2) / 6) % 4);
                arb_tab[c].ev = 1'b1;
            end
            arb_tab[c].ed = last_d;
            arb_tab[c].es = last_s;
        end

        mon_tab[0]  = '{33'd0,                                  1'b0, 16'd0};
        mon_tab[1]  = '{grp(0, 0, 0, 1),                        1'b1, 16'd1};
        mon_tab[2]  = '{grp(0, 1, 1, 1),                        1'b0, 16'd1};
        mon_tab[3]  = '{grp(0, 1, 1, 0),                        1'b1, 16'd2};
        mon_tab[4]  = '{33'd0,                                  1'b0, 16'd2};
        mon_tab[5]  = '{grp(0, 1, 1, 0),                        1'b0, 16'd2};
        mon_tab[6]  = '{grp(0, 0, 0, 1),                        1'b1, 16'd3};
        mon_tab[7]  = '{grp(0, 0, 0, 1),                        1'b0, 16'd3};
        mon_tab[8]  = '{33'd0,                                  1'b0, 16'd3};
        mon_tab[9]  = '{grp(0, 0, 0, 1) | grp(5, 0, 0, 1),      1'b1, 16'd4};
        mon_tab[10] = '{grp(10, 1, 1, 0),                       1'b0, 16'd4};
        mon_tab[11] = '{grp(10, 1, 1, 1),                       1'b0, 16'd4};
        mon_tab[12] = '{grp(10, 1, 1, 0),                       1'b1, 16'd5};

        for (int k = 0; k < NR; k++)
            words[k] = 30'(100 * (k + 1));
        reset_n   = 1'b0;
        req_valid = '0;
        tsv_mon   = '0;
        pack();

        #1;
        chk("rst_enc_data",   32'(enc_data),   32'd0);
        chk("rst_enc_valid",  32'(enc_valid),  32'd0);
        chk("rst_enc_src",    32'(enc_src),    32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_err_range",  32'(err_range),  32'd0);
        chk("rst_err_src",    32'(err_src),    32'd0);
        chk("rst_rule_viol",  32'(rule_viol),  32'd0);
        chk("rst_viol_count", 32'(viol_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Round-robin streaming table.
        for (int c = 0; c < 30; c++) begin
            req_valid = arb_tab[c].valid;
            chk($sformatf("rr_ready[%0d]", c),  32'(req_ready), 32'(arb_tab[c].ready));
            chk($sformatf("rr_ev[%0d]", c),     32'(enc_valid), 32'(arb_tab[c].ev));
            chk($sformatf("rr_ed[%0d]", c),     32'(enc_data),  32'(arb_tab[c].ed));
            chk($sformatf("rr_es[%0d]", c),     32'(enc_src),   32'(arb_tab[c].es));
            tick();
        end

        // Range boundary on requester 2 (rr_ptr is 1 here).
        words[2]  = MAXW;
        pack();
        req_valid = 4'b0100;
        tick();
        chk("rng_ready", 32'(req_ready), 32'd4);
        tick();
        chk("rng_max_ev",  32'(enc_valid), 32'd1);
        chk("rng_max_ed",  32'(enc_data),  32'(MAXW));
        chk("rng_max_es",  32'(enc_src),   32'd2);
        chk("rng_max_err", 32'(err_range), 32'd0);
        tick();
        chk("rng_over_ev",   32'(enc_valid), 32'd0);
        chk("rng_over_ed",   32'(enc_data),  32'(MAXW));
        chk("rng_over_err",  32'(err_range), 32'd1);
        chk("rng_over_esrc", 32'(err_src),   32'd2);
        req_valid = 4'b0000;
        tick();
        chk("rng_sw_ready", 32'(req_ready), 32'd0);
        chk("rng_sw_err",   32'(err_range), 32'd0);
        chk("rng_sw_esrc",  32'(err_src),   32'd2);
        tick();

        // Requester 1 drops valid after two beats (rr_ptr is 3 here).
        words[1]  = 30'd500;
        pack();
        req_valid = 4'b0010;
        tick();
        chk("drop_ready", 32'(req_ready), 32'd2);
        tick();
        chk("drop_b0_ed", 32'(enc_data), 32'd500);
        chk("drop_b0_es", 32'(enc_src),  32'd1);
        tick();
        chk("drop_b1_ed", 32'(enc_data), 32'd501);
        chk("drop_b1_ev", 32'(enc_valid), 32'd1);
        req_valid = 4'b0000;
        chk("drop_b1_ready", 32'(req_ready), 32'd2);
        tick();
        chk("drop_sw_ready", 32'(req_ready), 32'd0);
        chk("drop_sw_ev",    32'(enc_valid), 32'd0);
        tick();
        words[0]  = 30'd600;
        words[2]  = 30'd356;
        words[3]  = 30'd700;
        pack();
        req_valid = 4'b1101;
        tick();
        chk("drop_next_owner", 32'(req_ready), 32'd4);
        req_valid = 4'b0100;
        tick();
        chk("w356_ev", 32'(enc_valid), 32'd1);
        chk("w356_ed", 32'(enc_data),  32'd356);
        chk("w356_es", 32'(enc_src),   32'd2);
        req_valid = 4'b0000;

        // Ten idle cycles: encoder input must stay static.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_ev[%0d]", i), 32'(enc_valid), 32'd0);
            chk($sformatf("idle_ed[%0d]", i), 32'(enc_data),  32'd356);
        end

        // TSV rule monitor table.
        for (int r = 0; r < 13; r++) begin
            tsv_mon = mon_tab[r].tsv;
            tick();
            chk($sformatf("mon_viol[%0d]", r), 32'(rule_viol),  32'(mon_tab[r].viol));
            chk($sformatf("mon_cnt[%0d]", r),  32'(viol_count), 32'(mon_tab[r].cnt));
        end

        // Alternating 001/110 on group 0 violates every cycle; counter must saturate.
        for (int i = 0; i < 65600; i++) begin
            tsv_mon = (i % 2 == 0) ? grp(0, 0, 0, 1) : grp(0, 1, 1, 0);
            tick();
        end
        chk("sat_viol", 32'(rule_viol),  32'd1);
        chk("sat_cnt",  32'(viol_count), 32'hFFFF);
        tsv_mon = '0;
        tick();
        chk("sat_hold_viol", 32'(rule_viol),  32'd0);
        chk("sat_hold_cnt",  32'(viol_count), 32'hFFFF);

        // Reset mid-burst of requester 3 (rr_ptr is 3 here).
        words[3]  = 30'd700;
        pack();
        req_valid = 4'b1000;
        tick();
        chk("mrst_ready", 32'(req_ready), 32'd8);
        tick();
        tick();
        chk("mrst_pre_ed", 32'(enc_data), 32'd701);
        chk("mrst_pre_es", 32'(enc_src),  32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_enc_data",   32'(enc_data),   32'd0);
        chk("mrst_enc_valid",  32'(enc_valid),  32'd0);
        chk("mrst_enc_src",    32'(enc_src),    32'd0);
        chk("mrst_req_ready",  32'(req_ready),  32'd0);
        chk("mrst_err_src",    32'(err_src),    32'd0);
        chk("mrst_viol_count", 32'(viol_count), 32'd0);
        words[1]  = 30'd800;
        pack();
        req_valid = 4'b1010;
        tick();
        reset_n = 1'b1;
        chk("mrst_idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("mrst_regrant", 32'(req_ready), 32'd2);
        tick();
        chk("mrst_first_ed", 32'(enc_data),  32'd800);
        chk("mrst_first_es", 32'(enc_src),   32'd1);
        chk("mrst_first_ev", 32'(enc_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
